// File: rtl/fetch_queue.sv
// fetch_queue: prefetching instruction fetch unit.
// Issues one word request at a time over a req/gnt/rvalid handshake. Fetched
// {pc, inst, notlist} entries are buffered in a DEPTH-entry queue and handed
// to ID with a valid/ready handshake. A redirect (exception, then branch)
// flushes the queue and discards any response still in flight. A misaligned
// PC is never sent to memory. Instead it is queued once as {pc, 0, 0}, and
// fetch then parks until the next redirect.
//
// Optional feature: define FETCH_BYPASS_EN to present a response to ID in the
// same cycle it arrives when the queue is empty.
//
// Ports:
//   clk, resetn               clock, asynchronous active-low reset
//   inst_req/inst_addr        request to instruction memory (addr = fetch pc)
//   inst_gnt                  memory accepted the address
//   inst_rvalid/inst_rdata    in-order read response
//   jbr_bus                   {jbr_taken, jbr_target}
//   exc_bus                   {exc_valid, exc_pc}, wins over jbr_bus
//   ID_ready                  ID consumes the head entry
//   IF_over                   head entry valid
//   IF_ID_bus                 {pc, inst, notlist}, zero when IF_over=0
//   IF_pc, IF_inst            display copies of the head entry
module fetch_queue #(
    parameter logic [31:0] START_ADDR = 32'hbfc00000,
    parameter int          DEPTH      = 4
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_gnt,
    input  logic        inst_rvalid,
    input  logic [31:0] inst_rdata,
    input  logic [32:0] jbr_bus,
    input  logic [32:0] exc_bus,
    input  logic        ID_ready,
    output logic        IF_over,
    output logic [64:0] IF_ID_bus,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HALT} state_t;

    state_t        state;
    logic [31:0]   pc, pend_pc;
    logic          drop;
    logic [AW:0]   count, count_nxt;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [64:0]   mem [DEPTH];

    logic        redirect, aligned, not_full, head_vld;
    logic        resp_ok, mis_push, byp, byp_take, push, pop;
    logic [31:0] target;
    logic [64:0] push_data, head;

    assign redirect = exc_bus[32] | jbr_bus[32];
    assign target   = exc_bus[32] ? exc_bus[31:0] : jbr_bus[31:0];
    assign aligned  = (pc[1:0] == 2'b00);
    assign not_full = (count < FULL);
    assign head_vld = (count != '0);

    // Request decode uses registers only: no path from the redirect buses.
    assign inst_req  = (state == S_REQ) && aligned;
    assign inst_addr = pc;

    assign resp_ok   = (state == S_WAIT) && inst_rvalid && !drop;
    assign mis_push  = (state == S_REQ) && !aligned && not_full;
    assign push_data = mis_push ? {pc, 32'h0, 1'b0} : {pend_pc, inst_rdata, 1'b1};

`ifdef FETCH_BYPASS_EN
    // A response landing in an empty queue is shown to ID immediately; a
    // response coinciding with a redirect is discarded, so it never bypasses.
    assign byp = resp_ok && !head_vld && !redirect;
`else
    assign byp = 1'b0;
`endif

    // A bypassed entry taken by ID in its arrival cycle is never written.
    assign byp_take  = byp && ID_ready;
    assign push      = (resp_ok || mis_push) && !byp_take;
    assign pop       = head_vld && ID_ready;
    assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        head = '0;
        if (byp)           head = {pend_pc, inst_rdata, 1'b1};
        else if (head_vld) head = mem[rd_ptr];
    end

    assign IF_over   = head_vld || byp;
    assign IF_ID_bus = head;
    assign IF_pc     = head[64:33];
    assign IF_inst   = head[32:1];

    always_ff @(posedge clk) begin
        if (push && !redirect) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            pc      <= START_ADDR;
            pend_pc <= START_ADDR;
            drop    <= 1'b0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else if (redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            pc     <= target;
            // A request is still owed a response: wait it out and drop it.
            if ((state == S_WAIT && !inst_rvalid) || (state == S_REQ && inst_req && inst_gnt)) begin
                state <= S_WAIT;
                drop  <= 1'b1;
            end else begin
                state <= S_REQ;
                drop  <= 1'b0;
            end
        end else begin
            count <= count_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case (state)
                S_IDLE: if (not_full) state <= S_REQ;
                S_REQ: begin
                    if (!aligned) begin
                        if (not_full) state <= S_HALT;
                    end else if (inst_gnt) begin
                        pend_pc <= pc;
                        pc      <= pc + 32'd4;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_rvalid) begin
                        drop  <= 1'b0;
                        state <= (count_nxt < FULL) ? S_REQ : S_IDLE;
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
